// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, the writeback request record and the hard-wired zero register index.
package wb_pkg;
    localparam int A_WIDTH = 5;
    localparam int D_WIDTH = 32;
    localparam logic [A_WIDTH-1:0] ZERO_REG = '0;
    typedef struct packed {
        logic [A_WIDTH-1:0] rd;
        logic [D_WIDTH-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of writeback requests, used as the load writeback queue.
// Ports: i_clk/i_rst (sync, active-high), i_push/i_din write side, i_pop/o_dout read side
// (o_dout is the current head, valid while !o_empty), o_full/o_empty status.
// Push while full and pop while empty are ignored.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    i_clk,
    input  logic    i_rst,
    input  logic    i_push,
    input  wb_req_t i_din,
    input  logic    i_pop,
    output wb_req_t o_dout,
    output logic    o_full,
    output logic    o_empty
);
    localparam int PW = $clog2(DEPTH);
    wb_req_t r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [PW:0] r_count;
    logic w_push;
    logic w_pop;
    assign o_full = r_count == (PW+1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign w_push = i_push && !o_full;
    assign w_pop = i_pop && !o_empty;
    assign o_dout = r_mem[r_rd];
    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr <= '0;
            r_rd <= '0;
            r_count <= '0;
        end else begin
            r_wr <= r_wr + PW'(w_push);
            r_rd <= r_rd + PW'(w_pop);
            r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
        end
    end
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr] <= i_din;
    end
endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: arbitrates ALU and load writebacks onto the register file write port and
// keeps a per-register busy scoreboard for read-after-write stalls.
// Ports: CLK/RST (sync, active-high); issue_valid/issue_rd set busy bits; rs1/rs2 -> hazard;
// alu_valid/alu_rd/alu_data (priority, no backpressure); ld_valid/ld_ready/ld_rd/ld_data
// (queued); WE3/A3/WD3 registered register file write port.
module regfile_writeback #(
    parameter int A_WIDTH = wb_pkg::A_WIDTH,
    parameter int D_WIDTH = wb_pkg::D_WIDTH,
    parameter int LQ_DEPTH = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               issue_valid,
    input  logic [A_WIDTH-1:0] issue_rd,
    input  logic [A_WIDTH-1:0] rs1,
    input  logic [A_WIDTH-1:0] rs2,
    output logic               hazard,
    input  logic               alu_valid,
    input  logic [A_WIDTH-1:0] alu_rd,
    input  logic [D_WIDTH-1:0] alu_data,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [A_WIDTH-1:0] ld_rd,
    input  logic [D_WIDTH-1:0] ld_data,
    output logic               WE3,
    output logic [A_WIDTH-1:0] A3,
    output logic [D_WIDTH-1:0] WD3
);
    import wb_pkg::*;
    logic [2**A_WIDTH-1:0] r_busy;
    logic [2**A_WIDTH-1:0] w_busy_nxt;
    wb_req_t w_ld_req;
    wb_req_t w_head;
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_we;
    logic [A_WIDTH-1:0] w_rd;
    logic [D_WIDTH-1:0] w_data;
    assign ld_ready = !w_full && !RST;
    assign w_push = ld_valid && ld_ready;
    // The queue only drains on cycles the ALU leaves the port free.
    assign w_pop = !alu_valid && !w_empty;
    assign w_rd = alu_valid ? alu_rd : w_head.rd;
    assign w_data = alu_valid ? alu_data : w_head.data;
    // A request to x0 is consumed but never reaches the port.
    assign w_we = (alu_valid || w_pop) && (w_rd != A_WIDTH'(ZERO_REG));
    assign w_ld_req = '{rd: ld_rd, data: ld_data};
    assign hazard = r_busy[rs1] | r_busy[rs2];
    // Clear before set so a same-cycle issue to the launched index keeps it busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_we) w_busy_nxt[w_rd] = 1'b0;
        if (issue_valid && issue_rd != A_WIDTH'(ZERO_REG)) w_busy_nxt[issue_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            WE3 <= 1'b0;
            A3 <= '0;
            WD3 <= '0;
            r_busy <= '0;
        end else begin
            WE3 <= w_we;
            r_busy <= w_busy_nxt;
            if (w_we) begin
                A3 <= w_rd;
                WD3 <= w_data;
            end
        end
    end
    wb_fifo #(.DEPTH(LQ_DEPTH)) u_lq (
        .i_clk(CLK),
        .i_rst(RST),
        .i_push(w_push),
        .i_din(w_ld_req),
        .i_pop(w_pop),
        .o_dout(w_head),
        .o_full(w_full),
        .o_empty(w_empty)
    );
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: scoreboard bench for the register file writeback initiator.
module tb_regfile_writeback;
    import wb_pkg::*;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic issue_valid = 1'b0;
    logic [4:0] issue_rd = '0;
    logic [4:0] rs1 = '0;
    logic [4:0] rs2 = '0;
    logic hazard;
    logic alu_valid = 1'b0;
    logic [4:0] alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic ld_valid = 1'b0;
    logic ld_ready;
    logic [4:0] ld_rd = '0;
    logic [31:0] ld_data = '0;
    logic WE3;
    logic [4:0] A3;
    logic [31:0] WD3;
    int n_cmp = 0;
    int n_bad = 0;
    wb_req_t exp_q[$];
    wb_req_t m_lq[$];
    logic [31:0] m_busy = '0;

    regfile_writeback #(.A_WIDTH(5), .D_WIDTH(32), .LQ_DEPTH(4)) dut (
        .CLK(CLK), .RST(RST),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1(rs1), .rs2(rs2), .hazard(hazard),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .WE3(WE3), .A3(A3), .WD3(WD3)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic quiet();
        issue_valid = 1'b0;
        alu_valid = 1'b0;
        ld_valid = 1'b0;
    endtask

    // One clock: check combinational outputs, advance the reference model, then check the port.
    task automatic step();
        logic acc;
        logic we;
        wb_req_t l;
        #1;
        chk("ld_ready", ld_ready, !RST && m_lq.size() < 4);
        if (!RST) chk("hazard", hazard, m_busy[rs1] | m_busy[rs2]);
        we = 1'b0;
        l = '0;
        if (RST) begin
            m_lq.delete();
            m_busy = '0;
        end else begin
            acc = ld_valid && m_lq.size() < 4;
            if (alu_valid) begin
                l = '{rd: alu_rd, data: alu_data};
                we = alu_rd != 5'd0;
            end else if (m_lq.size() > 0) begin
                l = m_lq.pop_front();
                we = l.rd != 5'd0;
            end
            if (acc) m_lq.push_back('{rd: ld_rd, data: ld_data});
            if (we) begin
                exp_q.push_back(l);
                m_busy[l.rd] = 1'b0;
            end
            if (issue_valid && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
        end
        @(posedge CLK);
        @(negedge CLK);
        chk("WE3", WE3, we);
        if (WE3 && exp_q.size() > 0) begin
            l = exp_q.pop_front();
            chk("A3", A3, l.rd);
            chk("WD3", WD3, l.data);
        end
    endtask

    initial begin
        RST = 1'b1;
        ld_valid = 1'b1;
        step();
        step();
        chk("rst_A3", A3, 0);
        chk("rst_WD3", WD3, 0);
        RST = 1'b0;
        quiet();
        #1 chk("ready_after_rst", ld_ready, 1);
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        step();
        quiet();
        step();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
        ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 32'h22;
        step();
        quiet();
        repeat (3) step();
        for (int i = 0; i < 5; i++) begin
            alu_valid = 1'b1; alu_rd = 5'(10 + i); alu_data = 32'hA000 + i;
            ld_valid = 1'b1; ld_rd = 5'(20 + i); ld_data = 32'hB000 + i;
            step();
        end
        quiet();
        repeat (6) step();
        rs1 = 5'd7; rs2 = 5'd1;
        issue_valid = 1'b1; issue_rd = 5'd7;
        step();
        quiet();
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h77;
        step();
        quiet();
        repeat (3) step();
        issue_valid = 1'b1; issue_rd = 5'd7;
        step();
        quiet();
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h700;
        issue_valid = 1'b1; issue_rd = 5'd7;
        step();
        quiet();
        step();
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h701;
        step();
        quiet();
        repeat (2) step();
        rs1 = 5'd0; rs2 = 5'd0;
        issue_valid = 1'b1; issue_rd = 5'd0;
        step();
        quiet();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
        step();
        quiet();
        step();
        for (int i = 0; i < 2; i++) begin
            alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h66;
            ld_valid = 1'b1; ld_rd = 5'(12 + i); ld_data = 32'hC000 + i;
            issue_valid = 1'b1; issue_rd = 5'(12 + i);
            step();
        end
        quiet();
        RST = 1'b1;
        step();
        RST = 1'b0;
        rs1 = 5'd12; rs2 = 5'd13;
        repeat (4) step();
        for (int i = 0; i < 400; i++) begin
            alu_valid = $urandom_range(0, 2) == 0;
            alu_rd = 5'($urandom_range(0, 31));
            alu_data = $urandom;
            ld_valid = $urandom_range(0, 1) == 1;
            ld_rd = 5'($urandom_range(0, 31));
            ld_data = $urandom;
            issue_valid = $urandom_range(0, 1) == 1;
            issue_rd = 5'($urandom_range(0, 31));
            rs1 = 5'($urandom_range(0, 31));
            rs2 = 5'($urandom_range(0, 31));
            step();
        end
        quiet();
        repeat (8) step();
        chk("exp_q_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
